mux4_rr_arbiter: RTL
====================

# mux4_rr_arbiter

Round-robin arbiter and sequencer for the 4:1 single-bit data multiplexer in the lab datapath. Four requesters compete for the shared mux output. The block grants exactly one at a time, drives the mux select lines (A1, A0) for the winner, and presents the selected data bit on a registered output. An optional hold timeout stops one requester from starving the others.

## Interface
- MAX_HOLD, 8: maximum consecutive grant cycles for one owner; used only when the timeout feature is compiled in; legal range 2..2^CNT_W.
- CNT_W, 4: width of the hold counter.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  4  request lines; req[i] high means requester i wants the mux.
- d  in  4  data bits D0..D3; d[i] is requester i's data.
- gnt  out  4  one-hot grant; all zero when idle.
- sel  out  2  mux select: sel[1]=A1, sel[0]=A0; equals the owner index while granted.
- busy  out  1  high while a grant is active.
- y  out  1  registered mux output: d[sel] when busy, else 0.

## Operation
- State machine states: IDLE and GRANT. Internal state: ptr[1:0] (round-robin priority pointer), owner[1:0], cnt[CNT_W-1:0].
- Search rule: scan req in cyclic order ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first set bit wins.
- IDLE:
  - gnt=0 and busy=0; sel holds its last value.
  - If any req bit is set, the winner becomes owner: gnt=1<<owner, sel=owner, busy=1, cnt=0, and the state moves to GRANT.
- GRANT, owner still requesting (req[owner]=1):
  - The grant holds and cnt increments.
- GRANT, owner releases (req[owner]=0):
  - ptr ← owner+1 (mod 4, so 3 wraps to 0).
  - A new search runs from the new ptr on the same edge. If a winner exists, the grant hands off directly with no idle cycle, and cnt resets to 0.
  - If no winner exists, the state goes to IDLE and gnt clears.
- y register:
  - Each edge: y ← (next busy) ? d[next sel] : 0.
  - y therefore reflects the d value sampled at the edge where the grant is issued or continues.
- Requests from non-owners have no effect while the owner holds the grant. They are served in round-robin order afterwards.
- A requester that drops req before being granted is skipped; no request is latched.
- gnt, sel and busy are registered outputs; no combinational path from req to gnt.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - Outputs: gnt=0, sel=0, busy=0, y=0.
  - Internal: ptr=0, cnt=0, state IDLE.
- After reset release, the first grant can occur on the first rising edge at which req≠0.
- Request to grant latency: 1 edge. req sampled at edge N gives gnt/sel/busy valid after edge N.
- Release to handoff: 1 edge. req[owner] low at edge N gives the new owner's gnt after edge N.
- Data latency: y after edge N equals d[sel] sampled at edge N.
- Simultaneous events:
  - If the owner releases while others request on the same edge, the handoff goes to the first requester from owner+1.
  - If the owner re-asserts req on the edge after release, it competes normally at lowest priority.

## Configuration
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - When, in GRANT, cnt reaches MAX_HOLD-1 while req[owner]=1 and another req bit is set, the grant is forcibly released on that edge.
  - A forced release rotates exactly like a voluntary release: ptr←owner+1, then search and hand off.
  - If no other requester is pending, the owner keeps the grant and cnt restarts at 0.
- Undefined: an owner holds the grant indefinitely while req[owner]=1. The counter logic is absent and MAX_HOLD is ignored.

## Test plan
- Reset mid-grant: req=0010, wait 3 edges, pulse rst_n low between edges → gnt=0000, sel=00, busy=0 and y=0 immediately; ptr=0, so req=1010 then grants requester 1.
- Round-robin from reset: req=1111 held; each owner drops its req for one edge on release → grant order 0,1,2,3,0; sel=00,01,10,11,00; no idle cycle between grants.
- Data path: req=0100, d=0100 → after 1 edge gnt=0100, sel=10, busy=1; then y=1. With d[2]=0 on the next edge, y=0 one edge later.
- Skip and wrap: owner 3 releases while req=0001 → next edge gnt=0001, sel=00, ptr=0; with req=0000 after release → IDLE, gnt=0, y=0.
- Timeout (with ARB_TIMEOUT_EN, MAX_HOLD=4): req=0011 held → requester 0 holds 4 cycles, then grant moves to 1 for 4 cycles, then back to 0. Without the macro, requester 0 holds for as long as req[0]=1.
- Lone owner with timeout: req=0001 only, MAX_HOLD=4 → grant never drops and busy stays 1 for 20 cycles.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for the shared 4:1 single-bit mux: one-hot grant, select lines and registered data.
// Optional hold timeout is compiled in with `define ARB_TIMEOUT_EN (uses MAX_HOLD / CNT_W).
//
// state | meaning
// IDLE  | no owner; gnt=0, busy=0, sel keeps its last value
// GRANT | owner holds the mux; sel=owner, gnt=1<<owner

module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] d,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       y
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state, state_nx;
  logic [1:0] ptr, ptr_nx;
  logic [1:0] owner, owner_nx;
  logic       busy_nx;
  logic [2:0] pick_idle, pick_rel;
  logic [1:0] rel_start;
  logic       rel, force_rel;

  if (MAX_HOLD < 2 || MAX_HOLD > (1 << CNT_W)) begin : g_bad_cfg
    $error("mux4_rr_arbiter: MAX_HOLD must be in 2..2**CNT_W");
  end

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign rel_start = owner + 2'd1;
  assign pick_idle = rr_pick(req, ptr);
  assign pick_rel  = rr_pick(req, rel_start);
  assign rel       = (state == GRANT) && !req[owner];
  assign sel       = owner;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             at_limit;
  logic [3:0]       others;

  assign at_limit  = (cnt == CNT_W'(MAX_HOLD - 1));
  assign others    = req & ~(4'b0001 << owner);
  assign force_rel = (state == GRANT) && req[owner] && at_limit && (others != 4'b0000);
`else
  assign force_rel = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    owner_nx = owner;
`ifdef ARB_TIMEOUT_EN
    cnt_nx   = cnt;
`endif
    case (state)
      IDLE: begin
        if (pick_idle[2]) begin
          state_nx = GRANT;
          owner_nx = pick_idle[1:0];
`ifdef ARB_TIMEOUT_EN
          cnt_nx   = '0;
`endif
        end
      end
      GRANT: begin
        if (rel || force_rel) begin
          // Forced and voluntary releases rotate identically; the old owner ends up last in the scan.
          ptr_nx = rel_start;
`ifdef ARB_TIMEOUT_EN
          cnt_nx = '0;
`endif
          if (pick_rel[2]) begin
            owner_nx = pick_rel[1:0];
          end else begin
            state_nx = IDLE;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          cnt_nx = at_limit ? '0 : cnt + 1'b1;
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy_nx = (state_nx == GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'd0;
      owner <= 2'd0;
      gnt   <= 4'b0000;
      busy  <= 1'b0;
      y     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      owner <= owner_nx;
      busy  <= busy_nx;
      gnt   <= busy_nx ? (4'b0001 << owner_nx) : 4'b0000;
      y     <= busy_nx ? d[owner_nx] : 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt   <= cnt_nx;
`endif
    end
  end

endmodule
